// File: rtl/fadd_sched.sv
// fadd_sched: issues operations from two requesters into a shared fixed-latency fp adder and steers results back.
// Build option: FADD_SCHED_RR_EN selects round-robin arbitration; the default is fixed priority to requester 0.
module fadd_sched #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic [31:0] res0_y,
  output logic        res0_ovf,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [31:0] res1_y,
  output logic        res1_ovf,
  output logic [31:0] fa_x1,
  output logic [31:0] fa_x2,
  input  logic [31:0] fa_y,
  input  logic        fa_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        ovf;
    logic [31:0] y;
  } res_t;

  logic [1:0]       credit;
  logic [1:0]       issue;
  logic [1:0]       pop;
  logic [1:0]       push;
  logic [1:0]       res_rdy;
  logic [1:0]       res_vld;
  res_t             head [2];
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_id;

  assign issue[0] = req0_valid & req0_ready;
  assign issue[1] = req1_valid & req1_ready;
  assign res_rdy  = {res1_ready, res0_ready};
  assign pop      = res_vld & res_rdy;

`ifdef FADD_SCHED_RR_EN
  logic prio;

  // Ready looks only at the other requester's valid, so a winner never waits on its own valid.
  assign req0_ready = ~rst & credit[0] & (~req1_valid | ~credit[1] | ~prio);
  assign req1_ready = ~rst & credit[1] & (~req0_valid | ~credit[0] |  prio);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (|issue) begin
      prio <= issue[0];
    end
  end
`else
  // Requester 0 always wins a conflict; requester 1 gets the slot only when 0 cannot use it.
  assign req0_ready = ~rst & credit[0];
  assign req1_ready = ~rst & credit[1] & (~req0_valid | ~credit[0]);
`endif

  // Operand register plus tag pipe that tracks which requester owns each adder slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_x1  <= '0;
      fa_x2  <= '0;
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[LATENCY-1:0], |issue};
      tag_id <= {tag_id[LATENCY-1:0], issue[1]};
      if (issue[0]) begin
        fa_x1 <= req0_x1;
        fa_x2 <= req0_x2;
      end else if (issue[1]) begin
        fa_x1 <= req1_x1;
        fa_x2 <= req1_x2;
      end
    end
  end

  assign push[0] = tag_v[LATENCY] & ~tag_id[LATENCY];
  assign push[1] = tag_v[LATENCY] &  tag_id[LATENCY];

  // Per-requester credit counter and result FIFO.
  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [CW-1:0] cnt;
    logic [CW-1:0] occ;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    res_t          mem [DEPTH];

    assign credit[g]  = (cnt < CW'(DEPTH));
    assign res_vld[g] = (occ != '0);
    assign head[g]    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        occ    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
          mem[AW'(k)] <= '0;
        end
      end else begin
        cnt <= cnt + CW'(issue[g]) - CW'(pop[g]);
        occ <= occ + CW'(push[g]) - CW'(pop[g]);
        if (push[g]) begin
          mem[wr_ptr] <= {fa_ovf, fa_y};
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop[g]) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  assign res0_valid = res_vld[0];
  assign res0_y     = head[0].y;
  assign res0_ovf   = head[0].ovf;
  assign res1_valid = res_vld[1];
  assign res1_y     = head[1].y;
  assign res1_ovf   = head[1].ovf;

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: behavioural fixed-latency fp adder, per-requester result scoreboard, directed scenarios.
module tb_fadd_sched;

  localparam int LAT = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x1 = '0, req0_x2 = '0, req1_x1 = '0, req1_x2 = '0;
  logic        res0_valid, res1_valid;
  logic        res0_ready = 1'b0, res1_ready = 1'b0;
  logic [31:0] res0_y, res1_y;
  logic        res0_ovf, res1_ovf;
  logic [31:0] fa_x1, fa_x2, fa_y;
  logic        fa_ovf;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          grant_log[$];
  logic [32:0] apipe [LAT];

  always #5 clk = ~clk;

  fadd_sched #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_y(res0_y), .res0_ovf(res0_ovf),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_y(res1_y), .res1_ovf(res1_ovf),
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y), .fa_ovf(fa_ovf)
  );

  function automatic real sp2real(input logic [31:0] a);
    real m;
    int  e;
    if (a[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(a[22:0]) / 8388608.0;
    e = int'(a[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return a[31] ? -m : m;
  endfunction

  // Returns {ovf, y}; ovf flags overflow to infinity or underflow to zero.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          se;
    r = sp2real(a) + sp2real(b);
    if (r == 0.0) return 33'd0;
    d  = $realtobits(r);
    se = int'(d[62:52]) - 1023 + 127;
    if (se >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    if (se <= 0)   return {1'b1, d[63], 31'd0};
    return {1'b0, d[63], se[7:0], d[51:29]};
  endfunction

  initial for (int k = 0; k < LAT; k++) apipe[k] = '0;

  always @(posedge clk) begin
    apipe[0] <= fp_add(fa_x1, fa_x2);
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign fa_y   = apipe[LAT-1][31:0];
  assign fa_ovf = apipe[LAT-1][32];

  // Scoreboard: records accepted ops and checks every consumed result in per-requester order.
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (!rst) begin
      if (req0_valid && req0_ready) begin exp_q0.push_back(fp_add(req0_x1, req0_x2)); grant_log.push_back(0); end
      if (req1_valid && req1_ready) begin exp_q1.push_back(fp_add(req1_x1, req1_x2)); grant_log.push_back(1); end
      if (res0_valid && res0_ready) begin
        checks++;
        if (exp_q0.size() == 0) begin errors++; $display("FAIL res0_order: unexpected result %h", {res0_ovf, res0_y}); end
        else begin
          e = exp_q0.pop_front();
          if ({res0_ovf, res0_y} !== e) begin errors++; $display("FAIL res0_data: got %h expected %h", {res0_ovf, res0_y}, e); end
        end
      end
      if (res1_valid && res1_ready) begin
        checks++;
        if (exp_q1.size() == 0) begin errors++; $display("FAIL res1_order: unexpected result %h", {res1_ovf, res1_y}); end
        else begin
          e = exp_q1.pop_front();
          if ({res1_ovf, res1_y} !== e) begin errors++; $display("FAIL res1_data: got %h expected %h", {res1_ovf, res1_y}, e); end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (dut.push[i]) begin
          checks++;
          if ((i == 0 ? dut.g_req[0].occ : dut.g_req[1].occ) == 3'(DEP) && !dut.pop[i]) begin
            errors++; $display("FAIL fifo_overflow: push into full fifo %0d", i);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; res0_ready = 0; res1_ready = 0;
    @(negedge clk);
    @(negedge clk);
    exp_q0.delete(); exp_q1.delete(); grant_log.delete();
    rst = 1'b0;
  endtask

  task automatic drain();
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      res0_ready = 1; res1_ready = 1;
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
    end
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++; $display("FAIL drain_timeout: pending %0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
    end
    @(negedge clk);
    res0_ready = 0; res1_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready, res0_valid, res1_valid, res0_ovf, res1_ovf} !== 6'b0 ||
        res0_y !== 32'h0 || res1_y !== 32'h0 || fa_x1 !== 32'h0 || fa_x2 !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: rdy=%b%b vld=%b%b y=%h/%h fa=%h/%h expected all 0",
        req0_ready, req1_ready, res0_valid, res1_valid, res0_y, res1_y, fa_x1, fa_x2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b%b expected 11", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single_op();
    @(negedge clk);
    req0_valid = 1; req0_x1 = 32'h3F800000; req0_x2 = 32'h40000000;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_accept: ready %b expected 1", req0_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req0_valid = 0;
      res0_ready = (k == 6);
      #1;
      if (k == 1 || k == 2) begin
        checks++;
        if (fa_x1 !== 32'h3F800000 || fa_x2 !== 32'h40000000) begin
          errors++; $display("FAIL fa_operands_t%0d: got %h/%h expected 3f800000/40000000", k, fa_x1, fa_x2);
        end
      end
      checks++;
      if (res0_valid !== (k == 6) || res1_valid !== 1'b0) begin
        errors++; $display("FAIL single_latency_t%0d: res0_valid=%b res1_valid=%b expected %b 0", k, res0_valid, res1_valid, k == 6);
      end
      if (k == 6) begin
        checks++;
        if (res0_y !== 32'h40400000 || res0_ovf !== 1'b0) begin
          errors++; $display("FAIL single_result: got %h ovf %b expected 40400000 ovf 0", res0_y, res0_ovf);
        end
      end
    end
    @(negedge clk);
    res0_ready = 0;
    #1;
    checks++;
    if (res0_valid !== 1'b0) begin errors++; $display("FAIL single_pop: res0_valid %b expected 0", res0_valid); end
  endtask

  task automatic test_ovf_route();
    int waited = 0;
    @(negedge clk);
    req1_valid = 1; req1_x1 = 32'h7F000000; req1_x2 = 32'h7F000000;
    @(negedge clk);
    req1_valid = 0;
    while (res1_valid !== 1'b1 && waited < 12) begin @(negedge clk); waited++; end
    #1;
    checks++;
    if (res1_valid !== 1'b1 || res1_y !== 32'h7F800000 || res1_ovf !== 1'b1 || res0_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_route: vld=%b y=%h ovf=%b res0_valid=%b expected 1 7f800000 1 0", res1_valid, res1_y, res1_ovf, res0_valid);
    end
    drain();
  endtask

`ifdef FADD_SCHED_RR_EN
  task automatic test_round_robin();
    do_reset();
    res0_ready = 1; res1_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req0_valid = 1; req0_x1 = 32'h3F800000 + (c << 16); req0_x2 = 32'h3F000000;
      req1_valid = 1; req1_x1 = 32'h40400000 + (c << 16); req1_x2 = 32'h3E800000;
      #1;
      checks++;
      if (req0_ready !== (c % 2 == 0) || req1_ready !== (c % 2 == 1)) begin
        errors++; $display("FAIL rr_grant_c%0d: ready=%b%b expected %b%b", c, req0_ready, req1_ready, c % 2 == 0, c % 2 == 1);
      end
    end
    drain();
    checks++;
    if (grant_log.size() != 8) begin errors++; $display("FAIL rr_count: %0d issues expected 8", grant_log.size()); end
    for (int k = 0; k < grant_log.size(); k++) begin
      checks++;
      if (grant_log[k] != k % 2) begin errors++; $display("FAIL rr_order_%0d: got %0d expected %0d", k, grant_log[k], k % 2); end
    end
  endtask
`else
  task automatic test_fixed_priority();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req0_valid = 1; req0_x1 = 32'h3F800000 + (c << 16); req0_x2 = 32'h3F000000;
      req1_valid = 1; req1_x1 = 32'h40400000 + (c << 16); req1_x2 = 32'h3E800000;
      #1;
      checks++;
      if (req0_ready !== (c < 4) || req1_ready !== (c >= 4)) begin
        errors++; $display("FAIL fixed_grant_c%0d: ready=%b%b expected %b%b", c, req0_ready, req1_ready, c < 4, c >= 4);
      end
    end
    drain();
  endtask
`endif

  task automatic test_credit();
    int acc = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      req0_valid = 1; req0_x1 = 32'h40000000 | (c << 16); req0_x2 = 32'h3F800000;
      req1_valid = (c == 10); req1_x1 = 32'h41000000; req1_x2 = 32'h40800000;
      #1;
      if (req0_ready) acc++;
      if (c == 10) begin
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL credit_req1_free: ready %b expected 1", req1_ready); end
      end
    end
    checks++;
    if (acc != 4) begin errors++; $display("FAIL credit_accepts: got %0d expected 4", acc); end
    @(negedge clk);
    req1_valid = 0; res0_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || res0_valid !== 1'b1) begin
      errors++; $display("FAIL credit_pop_cycle: ready=%b res0_valid=%b expected 0 1", req0_ready, res0_valid);
    end
    @(negedge clk);
    res0_ready = 0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL credit_return: ready %b expected 1", req0_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin errors++; $display("FAIL credit_reexhaust: ready %b expected 0", req0_ready); end
    req0_valid = 0;
  endtask

  task automatic test_push_pop();
    repeat (8) @(negedge clk);
    res0_ready = 1;
    #1;
    checks++;
    if (res0_valid !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL pp_full: res0_valid=%b ready=%b expected 1 0", res0_valid, req0_ready);
    end
    @(negedge clk);
    req0_valid = 1; req0_x1 = 32'h40A00000; req0_x2 = 32'h3F800000;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || res0_valid !== 1'b1) begin
      errors++; $display("FAIL pp_issue_and_pop: ready=%b res0_valid=%b expected 1 1", req0_ready, res0_valid);
    end
    @(negedge clk);
    res0_ready = 0; req0_x1 = 32'h40C00000;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL pp_count_held: ready %b expected 1", req0_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin errors++; $display("FAIL pp_count_full: ready %b expected 0", req0_ready); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req0_valid = 1; req0_x1 = 32'h40000000 + (c << 18); req0_x2 = 32'h40000000;
    end
    @(negedge clk);
    req0_valid = 0; res0_ready = 1; res1_ready = 1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, res0_valid, res1_valid, res0_ovf, res1_ovf} !== 6'b0 ||
        res0_y !== 32'h0 || res1_y !== 32'h0 || fa_x1 !== 32'h0 || fa_x2 !== 32'h0) begin
      errors++; $display("FAIL async_reset: rdy=%b%b vld=%b%b fa=%h/%h expected all 0",
        req0_ready, req1_ready, res0_valid, res1_valid, fa_x1, fa_x2);
    end
    @(negedge clk);
    @(negedge clk);
    exp_q0.delete(); exp_q1.delete(); grant_log.delete();
    rst = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (res0_valid !== 1'b0 || res1_valid !== 1'b0) begin
        errors++; $display("FAIL stale_result_c%0d: res_valid=%b%b expected 00", k, res0_valid, res1_valid);
      end
    end
    res0_ready = 0; res1_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_ovf_route();
`ifdef FADD_SCHED_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_credit();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
